// File: rtl/four_bit_half_adder.sv
// Registered unsigned adder built from per-bit half-adder terms and a
// ripple carry chain with no carry-in. Operands sampled on a rising edge
// with in_valid appear on the outputs one cycle later. Outputs hold their
// last result while in_valid is low; out_valid marks a fresh result.
module four_bit_half_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] prop,
    output logic [WIDTH-1:0] gen,
    output logic             out_valid
);

    logic [WIDTH-1:0] prop_c;
    logic [WIDTH-1:0] gen_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   chain;

    // Half-adder terms per bit, then ripple the carry from bit 0 upward.
    always_comb begin
        prop_c   = a ^ b;
        gen_c    = a & b;
        sum_c    = '0;
        chain    = '0;
        chain[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i]   = prop_c[i] ^ chain[i];
            chain[i+1] = gen_c[i] | (prop_c[i] & chain[i]);
        end
    end

    // Result register: reset clears everything, otherwise load on in_valid
    // and hold the data (but drop out_valid) when no operands arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= 1'b0;
            prop      <= '0;
            gen       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_c;
                carry <= chain[WIDTH];
                prop  <= prop_c;
                gen   <= gen_c;
            end
        end
    end

endmodule

// File: tb/tb_four_bit_half_adder.sv
// Self-checking bench for four_bit_half_adder: directed cases, an
// exhaustive operand sweep and a random stream with random valid/reset,
// all compared against a plain-arithmetic reference model.
module tb_four_bit_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       carry;
    logic [3:0] prop;
    logic [3:0] gen;
    logic       out_valid;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] m_sum;
    logic       m_carry;
    logic [3:0] m_prop;
    logic [3:0] m_gen;
    logic       m_valid;

    four_bit_half_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry     (carry),
        .prop      (prop),
        .gen       (gen),
        .out_valid (out_valid)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, settle to
    // the falling edge so outputs are sampled away from the active edge.
    task automatic apply(input logic r, input logic v, input logic [3:0] ta, input logic [3:0] tb);
        logic [4:0] total;
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb;
        @(posedge clk);
        total = 5'(ta) + 5'(tb);
        if (r) begin
            m_sum = 4'h0; m_carry = 1'b0; m_prop = 4'h0; m_gen = 4'h0; m_valid = 1'b0;
        end else if (v) begin
            m_sum   = total[3:0];
            m_carry = total[4];
            m_prop  = ta ^ tb;
            m_gen   = ta & tb;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s.sum", tag),   {4'h0, sum},   {4'h0, m_sum});
        check($sformatf("%s.carry", tag), {7'h0, carry}, {7'h0, m_carry});
        check($sformatf("%s.prop", tag),  {4'h0, prop},  {4'h0, m_prop});
        check($sformatf("%s.gen", tag),   {4'h0, gen},   {4'h0, m_gen});
        check($sformatf("%s.valid", tag), {7'h0, out_valid}, {7'h0, m_valid});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF;

        // Reset held two cycles with active operands.
        apply(1'b1, 1'b1, 4'hF, 4'hF);
        apply(1'b1, 1'b1, 4'hF, 4'hF);
        check("reset.sum",   {4'h0, sum},       8'h00);
        check("reset.carry", {7'h0, carry},     8'h00);
        check("reset.prop",  {4'h0, prop},      8'h00);
        check("reset.gen",   {4'h0, gen},       8'h00);
        check("reset.valid", {7'h0, out_valid}, 8'h00);

        // Exhaustive sweep, back-to-back valid.
        for (int i = 0; i < 256; i++) begin
            apply(1'b0, 1'b1, 4'(i >> 4), 4'(i));
            check_model($sformatf("exh[%0d]", i));
            check("exh.total", {3'b0, carry, sum}, 8'((i >> 4) + (i & 15)));
        end

        // Wrap case.
        apply(1'b0, 1'b1, 4'b1001, 4'b0111);
        check("wrap.sum",   {4'h0, sum},   8'h00);
        check("wrap.carry", {7'h0, carry}, 8'h01);
        check("wrap.prop",  {4'h0, prop},  8'h0E);
        check("wrap.gen",   {4'h0, gen},   8'h01);

        // No-carry case.
        apply(1'b0, 1'b1, 4'b0101, 4'b1010);
        check("nocarry.sum",   {4'h0, sum},   8'h0F);
        check("nocarry.carry", {7'h0, carry}, 8'h00);
        check("nocarry.prop",  {4'h0, prop},  8'h0F);
        check("nocarry.gen",   {4'h0, gen},   8'h00);

        // Hold when in_valid drops.
        apply(1'b0, 1'b1, 4'd3, 4'd4);
        check("hold.first.sum",   {4'h0, sum},       8'h07);
        check("hold.first.valid", {7'h0, out_valid}, 8'h01);
        apply(1'b0, 1'b0, 4'd9, 4'd9);
        check("hold.sum",   {4'h0, sum},       8'h07);
        check("hold.valid", {7'h0, out_valid}, 8'h00);
        check_model("hold");

        // Reset arriving with valid operands discards them.
        apply(1'b1, 1'b1, 4'd15, 4'd1);
        check("midrst.sum",   {4'h0, sum},       8'h00);
        check("midrst.carry", {7'h0, carry},     8'h00);
        check("midrst.valid", {7'h0, out_valid}, 8'h00);
        apply(1'b0, 1'b1, 4'd2, 4'd2);
        check("midrst.next.sum",   {4'h0, sum},       8'h04);
        check("midrst.next.valid", {7'h0, out_valid}, 8'h01);

        // Random stream with random valid gaps and occasional reset.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom));
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
